// File: rtl/regfile_param.sv
// Parameterised multi-read-port register file with optional hardwired zero
// register, write-to-read forwarding, a written-entry bitmap and a saturating write counter.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clock,
  input  logic                       ctrl_reset,
  input  logic                       ctrl_writeEnable,
  input  logic [ADDR_W-1:0]          ctrl_writeReg,
  input  logic [DATA_W-1:0]          data_writeReg,
  input  logic [NUM_RD*ADDR_W-1:0]   ctrl_readReg,
  output logic [NUM_RD*DATA_W-1:0]   data_readReg,
  output logic [(1<<ADDR_W)-1:0]     wr_strobe,
  output logic [(1<<ADDR_W)-1:0]     reg_valid,
  output logic [15:0]                wr_count
);

  localparam int   DEPTH   = 1 << ADDR_W;
  localparam logic ZERO_EN = (ZERO_REG != 0);
  localparam logic BYP_EN  = (BYPASS != 0);
  localparam logic [DEPTH-1:0] VALID_RST = {{(DEPTH-1){1'b0}}, ZERO_EN};

  logic [DATA_W-1:0] mem [DEPTH];
  logic              zero_addr_wr;
  logic              commit;

  assign zero_addr_wr = ZERO_EN && (ctrl_writeReg == '0);
  assign commit       = ctrl_writeEnable && !ctrl_reset && !zero_addr_wr;

  // One-hot decode built as a barrel shift of the commit bit, one stage per address bit.
  logic [DEPTH-1:0] dec_stage [ADDR_W+1];

  assign dec_stage[0] = {{(DEPTH-1){1'b0}}, commit};

  for (genvar s = 0; s < ADDR_W; s++) begin : g_dec
    assign dec_stage[s+1] = ctrl_writeReg[s] ? (dec_stage[s] << (1 << s)) : dec_stage[s];
  end

  assign wr_strobe = dec_stage[ADDR_W];

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      mem[ctrl_writeReg] <= data_writeReg;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      reg_valid <= VALID_RST;
    end else begin
      reg_valid <= reg_valid | wr_strobe;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      wr_count <= '0;
    end else if (commit && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // Zero-register masking is applied last so it also overrides a forwarded write to r0.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;

    assign raddr = ctrl_readReg[k*ADDR_W +: ADDR_W];

    always_comb begin
      rdata = mem[raddr];
      if (BYP_EN && commit && (raddr == ctrl_writeReg)) begin
        rdata = data_writeReg;
      end
      if (ZERO_EN && (raddr == '0)) begin
        rdata = '0;
      end
    end

    assign data_readReg[k*DATA_W +: DATA_W] = rdata;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clock` and `ctrl_reset`.
REQ-002 Parameter `DATA_W` SHALL default to 32 and set the register width in bits.
REQ-003 Parameter `ADDR_W` SHALL default to 5 and set the register address width, so DEPTH = 2^ADDR_W.
REQ-004 Parameter `NUM_RD` SHALL default to 2 and set the number of independent read ports (legal range 1..4).
REQ-005 Parameter `ZERO_REG` SHALL default to 1; when 1, register 0 is hardwired to zero.
REQ-006 Parameter `BYPASS` SHALL default to 1; when 1, same-cycle write data is forwarded to reads.
REQ-007 `clock`  input  1  rising-edge clock for all state.
REQ-008 `ctrl_reset`  input  1  synchronous active-high reset.
REQ-009 `ctrl_writeEnable`  input  1  write request this cycle.
REQ-010 `ctrl_writeReg`  input  ADDR_W  write address.
REQ-011 `data_writeReg`  input  DATA_W  write data.
REQ-012 `ctrl_readReg`  input  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-013 `data_readReg`  output  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-014 `wr_strobe`  output  DEPTH  combinational one-hot decoded write strobe.
REQ-015 `reg_valid`  output  DEPTH  registered bitmap of entries written since the last reset.
REQ-016 `wr_count`  output  16  registered count of committed writes, saturating.

Function
REQ-017 A write SHALL commit when ctrl_writeEnable=1, ctrl_reset=0, and the address is not (ZERO_REG=1 and addr=0); committed = this condition.
REQ-018 A committed write SHALL update entry[ctrl_writeReg] with data_writeReg at the rising edge.
- Written value is visible through the array one cycle later.
REQ-019 wr_strobe SHALL equal (1 << ctrl_writeReg) when the write commits, and all zeros otherwise.
- Decode is a shift-based log2(DEPTH)-stage mux chain, not a DEPTH-way compare.
REQ-020 Each read port SHALL return entry[ctrl_readReg[k]] combinationally, with zero added latency.
REQ-021 When BYPASS=1, a commit is in progress, and the read address equals ctrl_writeReg, the read port SHALL return data_writeReg instead of the array value.
REQ-022 When BYPASS=0, a read of the address being written SHALL return the old value until the clock edge.
REQ-023 When ZERO_REG=1, a read of address 0 SHALL return 0 in all cases, including while a write to address 0 is requested.
REQ-024 reg_valid[i] SHALL set on the edge that commits a write to i, and SHALL remain set until reset.
- When ZERO_REG=1, reg_valid[0] reads 1 permanently after reset.
REQ-025 wr_count SHALL increment by 1 on each committed write and SHALL hold at 16'hFFFF once reached (no wrap).
REQ-026 Any number of read ports SHALL be able to read the same or different addresses in the same cycle without interaction.
REQ-027 Writes to address DEPTH-1 SHALL decode correctly with no wrap or aliasing.
- Address width is exact, so no out-of-range addresses exist.
REQ-028 The block SHALL hold no multi-cycle state other than the array, reg_valid and wr_count.
- No handshake stalls: every request is accepted in the cycle it is presented.

Reset
REQ-029 On a rising edge with ctrl_reset=1, all entries SHALL clear to 0, wr_count SHALL clear to 0, and reg_valid SHALL clear to 0 (bit 0 = ZERO_REG).
REQ-030 A write requested in a reset cycle SHALL be dropped.
- wr_strobe is all zeros and bypass is suppressed in that cycle.
REQ-031 Reads during a reset cycle SHALL return pre-reset contents, and 0 on the following cycle.
REQ-032 Reset asserted mid-sequence SHALL take priority over any write in the same cycle.
- No partial update of any entry, reg_valid bit or wr_count.

Verification
REQ-033 Reset, then write 0xDEADBEEF to r7, then read r7 on port 0 next cycle -> data_readReg port0 = 0xDEADBEEF; reg_valid[7]=1; wr_count=1.
REQ-034 With BYPASS=1, write 0x12345678 to r3 while port 1 reads r3 in the same cycle -> port1 = 0x12345678 that cycle.
- Same stimulus with BYPASS=0 -> port1 = the old value (0 after reset).
REQ-035 With ZERO_REG=1, write 0xFFFFFFFF to r0 -> wr_strobe=0, read r0 = 0 in that cycle and the next, and wr_count unchanged.
REQ-036 Write to each of r1..r31 with data = address -> wr_strobe is one-hot (1<<i) each cycle, every read-back matches, and reg_valid = 0xFFFFFFFF.
REQ-037 Preload r5=0xA5A5A5A5, then assert ctrl_reset together with a write of 0x1 to r5 -> next cycle r5 = 0, reg_valid = 0x00000001, wr_count = 0.
REQ-038 Force wr_count to 0xFFFE, then do three committed writes -> wr_count reads 0xFFFF, 0xFFFF, 0xFFFF (no wrap).
